// File: rtl/chroma_cline_fetch_sequencer_pkg.sv
// Shared cache geometry and sequencer state encoding for the chroma
// reference cache front end.
package cache_configs_def;

    // log2 of cache-line width / height in chroma pixels
    localparam int unsigned C_L_H_SIZE_C = 3;
    localparam int unsigned C_L_V_SIZE_C = 2;

    typedef enum logic [1:0] {
        STATE_IDLE  = 2'd0,
        STATE_CALC  = 2'd1,
        STATE_ISSUE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/chroma_cline_fetch_sequencer_span_calc.sv
// Combinational span calculator: maps a block's start pixel and extent to
// the number of extra cache-line columns/rows it touches and the line count.
module chroma_cline_span_calc
    import cache_configs_def::*;
#(
    parameter int unsigned PIC_X_WDTH    = 11,
    parameter int unsigned PIC_Y_WDTH    = 11,
    parameter int unsigned CHMA_DIM_WDTH = 3,
    parameter int unsigned CHMA_DIM_HIGT = 3
) (
    input  logic [PIC_X_WDTH-1:0]    start_x_i,
    input  logic [PIC_Y_WDTH-1:0]    start_y_i,
    input  logic [CHMA_DIM_WDTH-1:0] wdt_i,
    input  logic [CHMA_DIM_HIGT-1:0] hgt_i,
    output logic [1:0]               dx_o,
    output logic [1:0]               dy_o,
    output logic [3:0]               cnt_o
);

    logic [PIC_X_WDTH-1:0] end_x;
    logic [PIC_Y_WDTH-1:0] end_y;
    logic [2:0]            ncol;
    logic [2:0]            nrow;
    logic [5:0]            prod;

    // Line-index difference taken on the two bits above the in-line offset;
    // modulo-4 subtraction handles coordinate wrap naturally.
    always_comb begin
        end_x = start_x_i + PIC_X_WDTH'(wdt_i);
        end_y = start_y_i + PIC_Y_WDTH'(hgt_i);
        dx_o  = end_x[C_L_H_SIZE_C+1:C_L_H_SIZE_C] - start_x_i[C_L_H_SIZE_C+1:C_L_H_SIZE_C];
        dy_o  = end_y[C_L_V_SIZE_C+1:C_L_V_SIZE_C] - start_y_i[C_L_V_SIZE_C+1:C_L_V_SIZE_C];
        ncol  = {1'b0, dx_o} + 3'd1;
        nrow  = {1'b0, dy_o} + 3'd1;
        prod  = {3'b000, ncol} * {3'b000, nrow};
        cnt_o = prod[3:0];
    end

endmodule

// File: rtl/chroma_cline_fetch_sequencer.sv
// Chroma cache-line fetch sequencer: accepts one reference block, computes
// the cache lines it covers and issues them in raster order.
// Optional performance counters: define CH_CLINE_SEQ_PERF_EN.
module chroma_cline_fetch_sequencer
    import cache_configs_def::*;
#(
    parameter int unsigned CHMA_DIM_WDTH = 3,
    parameter int unsigned CHMA_DIM_HIGT = 3,
    parameter int unsigned PIC_X_WDTH    = 11,
    parameter int unsigned PIC_Y_WDTH    = 11
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             blk_valid_in,
    output logic                             blk_ready_out,
    input  logic [PIC_X_WDTH-1:0]            start_x_in,
    input  logic [PIC_Y_WDTH-1:0]            start_y_in,
    input  logic [CHMA_DIM_WDTH-1:0]         rf_blk_wdt_in,
    input  logic [CHMA_DIM_HIGT-1:0]         rf_blk_hgt_in,
    input  logic                             flush_in,
    output logic                             cline_valid_out,
    input  logic                             cline_ready_in,
    output logic [PIC_X_WDTH-C_L_H_SIZE_C-1:0] cline_x_out,
    output logic [PIC_Y_WDTH-C_L_V_SIZE_C-1:0] cline_y_out,
    output logic                             cline_last_out,
    output logic [3:0]                       cline_cnt_out
`ifdef CH_CLINE_SEQ_PERF_EN
    ,
    output logic [31:0]                      perf_blk_cnt_out,
    output logic [31:0]                      perf_cline_cnt_out
`endif
);

    localparam int unsigned CX_W = PIC_X_WDTH - C_L_H_SIZE_C;
    localparam int unsigned CY_W = PIC_Y_WDTH - C_L_V_SIZE_C;

    seq_state_e               state_q, state_d;
    logic [PIC_X_WDTH-1:0]    sx_q, sx_d;
    logic [PIC_Y_WDTH-1:0]    sy_q, sy_d;
    logic [CHMA_DIM_WDTH-1:0] wdt_q, wdt_d;
    logic [CHMA_DIM_HIGT-1:0] hgt_q, hgt_d;
    logic [1:0]               dx_q, dx_d, dy_q, dy_d;
    logic [1:0]               ix_q, ix_d, iy_q, iy_d;
    logic [3:0]               cnt_q, cnt_d;
    logic [CX_W-1:0]          bx_q, bx_d;
    logic [CY_W-1:0]          by_q, by_d;

    logic [1:0] span_dx, span_dy;
    logic [3:0] span_cnt;
    logic       accept, hs, at_row_end;

    chroma_cline_span_calc #(
        .PIC_X_WDTH   (PIC_X_WDTH),
        .PIC_Y_WDTH   (PIC_Y_WDTH),
        .CHMA_DIM_WDTH(CHMA_DIM_WDTH),
        .CHMA_DIM_HIGT(CHMA_DIM_HIGT)
    ) u_span (
        .start_x_i(sx_q),
        .start_y_i(sy_q),
        .wdt_i    (wdt_q),
        .hgt_i    (hgt_q),
        .dx_o     (span_dx),
        .dy_o     (span_dy),
        .cnt_o    (span_cnt)
    );

    // Next-state and output decode; flush overrides any same-cycle handshake.
    always_comb begin
        state_d    = state_q;
        sx_d       = sx_q;
        sy_d       = sy_q;
        wdt_d      = wdt_q;
        hgt_d      = hgt_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        ix_d       = ix_q;
        iy_d       = iy_q;
        cnt_d      = cnt_q;
        bx_d       = bx_q;
        by_d       = by_q;

        blk_ready_out   = (state_q == STATE_IDLE);
        cline_valid_out = (state_q == STATE_ISSUE);
        at_row_end      = (ix_q == dx_q);
        cline_last_out  = cline_valid_out && at_row_end && (iy_q == dy_q);
        cline_x_out     = bx_q + CX_W'(ix_q);
        cline_y_out     = by_q + CY_W'(iy_q);
        cline_cnt_out   = cnt_q;
        accept          = blk_ready_out && blk_valid_in && !flush_in;
        hs              = cline_valid_out && cline_ready_in && !flush_in;

        case (state_q)
            STATE_IDLE: begin
                if (accept) begin
                    sx_d    = start_x_in;
                    sy_d    = start_y_in;
                    wdt_d   = rf_blk_wdt_in;
                    hgt_d   = rf_blk_hgt_in;
                    state_d = STATE_CALC;
                end
            end
            STATE_CALC: begin
                if (flush_in) begin
                    state_d = STATE_IDLE;
                end else begin
                    dx_d    = span_dx;
                    dy_d    = span_dy;
                    cnt_d   = span_cnt;
                    bx_d    = sx_q[PIC_X_WDTH-1:C_L_H_SIZE_C];
                    by_d    = sy_q[PIC_Y_WDTH-1:C_L_V_SIZE_C];
                    ix_d    = '0;
                    iy_d    = '0;
                    state_d = STATE_ISSUE;
                end
            end
            STATE_ISSUE: begin
                if (flush_in) begin
                    state_d = STATE_IDLE;
                end else if (hs) begin
                    if (at_row_end) begin
                        ix_d = '0;
                        if (iy_q == dy_q) begin
                            iy_d    = '0;
                            state_d = STATE_IDLE;
                        end else begin
                            iy_d = iy_q + 2'd1;
                        end
                    end else begin
                        ix_d = ix_q + 2'd1;
                    end
                end
            end
            default: state_d = STATE_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= STATE_IDLE;
            sx_q    <= '0;
            sy_q    <= '0;
            wdt_q   <= '0;
            hgt_q   <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            ix_q    <= '0;
            iy_q    <= '0;
            cnt_q   <= '0;
            bx_q    <= '0;
            by_q    <= '0;
        end else begin
            state_q <= state_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            wdt_q   <= wdt_d;
            hgt_q   <= hgt_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            ix_q    <= ix_d;
            iy_q    <= iy_d;
            cnt_q   <= cnt_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
        end
    end

`ifdef CH_CLINE_SEQ_PERF_EN
    logic [31:0] perf_blk_q, perf_cline_q;

    // Saturating activity counters; only reset clears them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_blk_q   <= '0;
            perf_cline_q <= '0;
        end else begin
            if (accept && (perf_blk_q != '1)) begin
                perf_blk_q <= perf_blk_q + 32'd1;
            end
            if (hs && (perf_cline_q != '1)) begin
                perf_cline_q <= perf_cline_q + 32'd1;
            end
        end
    end

    assign perf_blk_cnt_out   = perf_blk_q;
    assign perf_cline_cnt_out = perf_cline_q;
`else
    // No performance counters in this build.
`endif

endmodule

// File: tb/tb_chroma_cline_fetch_sequencer.sv
// Self-checking bench for chroma_cline_fetch_sequencer. Expected cache lines
// are derived by walking every pixel of the block, independently of the RTL
// span arithmetic. Counter checks are enabled with CH_CLINE_SEQ_PERF_EN.
module tb_chroma_cline_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        blk_valid_in = 1'b0;
    logic        blk_ready_out;
    logic [10:0] start_x_in = '0;
    logic [10:0] start_y_in = '0;
    logic [2:0]  rf_blk_wdt_in = '0;
    logic [2:0]  rf_blk_hgt_in = '0;
    logic        flush_in = 1'b0;
    logic        cline_valid_out;
    logic        cline_ready_in = 1'b0;
    logic [7:0]  cline_x_out;
    logic [8:0]  cline_y_out;
    logic        cline_last_out;
    logic [3:0]  cline_cnt_out;
`ifdef CH_CLINE_SEQ_PERF_EN
    logic [31:0] perf_blk_cnt_out;
    logic [31:0] perf_cline_cnt_out;
`endif

    chroma_cline_fetch_sequencer #(
        .CHMA_DIM_WDTH(3),
        .CHMA_DIM_HIGT(3),
        .PIC_X_WDTH   (11),
        .PIC_Y_WDTH   (11)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .blk_valid_in   (blk_valid_in),
        .blk_ready_out  (blk_ready_out),
        .start_x_in     (start_x_in),
        .start_y_in     (start_y_in),
        .rf_blk_wdt_in  (rf_blk_wdt_in),
        .rf_blk_hgt_in  (rf_blk_hgt_in),
        .flush_in       (flush_in),
        .cline_valid_out(cline_valid_out),
        .cline_ready_in (cline_ready_in),
        .cline_x_out    (cline_x_out),
        .cline_y_out    (cline_y_out),
        .cline_last_out (cline_last_out),
        .cline_cnt_out  (cline_cnt_out)
`ifdef CH_CLINE_SEQ_PERF_EN
        ,
        .perf_blk_cnt_out  (perf_blk_cnt_out),
        .perf_cline_cnt_out(perf_cline_cnt_out)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned sx;
        int unsigned sy;
        int unsigned w;
        int unsigned h;
        int unsigned exp_cnt;
        bit          rnd_ready;
    } vec_t;

    typedef struct {
        logic [7:0] x;
        logic [8:0] y;
        logic       last;
    } line_t;

    line_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned exp_cnt_g;
    int unsigned exp_blk = 0;
    int unsigned exp_cl  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Build the expected line list by visiting every pixel of the block.
    task automatic push_exp(input int unsigned sx, input int unsigned sy,
                            input int unsigned w, input int unsigned h);
        int unsigned cols[$];
        int unsigned rows[$];
        int unsigned c;
        line_t l;
        for (int unsigned p = 0; p <= w; p++) begin
            c = ((sx + p) % 2048) >> 3;
            if (cols.size() == 0 || cols[cols.size()-1] != c) cols.push_back(c);
        end
        for (int unsigned p = 0; p <= h; p++) begin
            c = ((sy + p) % 2048) >> 2;
            if (rows.size() == 0 || rows[rows.size()-1] != c) rows.push_back(c);
        end
        for (int r = 0; r < rows.size(); r++) begin
            for (int k = 0; k < cols.size(); k++) begin
                l.x    = 8'(cols[k]);
                l.y    = 9'(rows[r]);
                l.last = (r == rows.size() - 1) && (k == cols.size() - 1);
                exp_q.push_back(l);
            end
        end
    endtask

    task automatic check_perf(input string tag);
`ifdef CH_CLINE_SEQ_PERF_EN
        chk({tag, "_perf_blk"}, 64'(perf_blk_cnt_out), 64'(exp_blk));
        chk({tag, "_perf_cline"}, 64'(perf_cline_cnt_out), 64'(exp_cl));
`endif
    endtask

    task automatic send_block(input int unsigned sx, input int unsigned sy,
                              input int unsigned w, input int unsigned h);
        int wt = 0;
        @(negedge clk);
        while (!blk_ready_out && wt < 50) begin
            @(negedge clk);
            wt++;
        end
        if (!blk_ready_out) begin
            chk("blk_ready_timeout", 64'(blk_ready_out), 64'd1);
        end
        start_x_in    = 11'(sx);
        start_y_in    = 11'(sy);
        rf_blk_wdt_in = 3'(w);
        rf_blk_hgt_in = 3'(h);
        cline_ready_in = 1'b0;
        blk_valid_in  = 1'b1;
        @(posedge clk);
        #1 blk_valid_in = 1'b0;
        exp_blk++;
        @(negedge clk);
        chk("calc_valid_low", 64'(cline_valid_out), 64'd0);
        chk("calc_blk_ready_low", 64'(blk_ready_out), 64'd0);
    endtask

    // Drain the expected queue through the handshake, checking order, the
    // first-request latency, line count and stability under backpressure.
    task automatic run_lines(input bit rnd, output int n);
        int cyc = 0;
        bit held = 1'b0;
        line_t h;
        line_t e;
        n = 0;
        while (exp_q.size() > 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                chk("first_valid_latency", 64'(cline_valid_out), 64'd1);
                chk("cline_cnt", 64'(cline_cnt_out), 64'(exp_cnt_g));
            end
            if (held) begin
                chk("stall_valid", 64'(cline_valid_out), 64'd1);
                chk("stall_x", 64'(cline_x_out), 64'(h.x));
                chk("stall_y", 64'(cline_y_out), 64'(h.y));
                chk("stall_last", 64'(cline_last_out), 64'(h.last));
            end
            cline_ready_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            held = 1'b0;
            if (cline_valid_out) begin
                if (cline_ready_in) begin
                    e = exp_q.pop_front();
                    chk("line_x", 64'(cline_x_out), 64'(e.x));
                    chk("line_y", 64'(cline_y_out), 64'(e.y));
                    chk("line_last", 64'(cline_last_out), 64'(e.last));
                    n++;
                    exp_cl++;
                end else begin
                    held   = 1'b1;
                    h.x    = cline_x_out;
                    h.y    = cline_y_out;
                    h.last = cline_last_out;
                end
            end
        end
        if (exp_q.size() > 0) begin
            chk("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        @(negedge clk);
        cline_ready_in = 1'b0;
        chk("post_block_valid_low", 64'(cline_valid_out), 64'd0);
        chk("post_block_ready_high", 64'(blk_ready_out), 64'd1);
    endtask

    // Abort the 2x3 block while its second request is on the bus.
    task automatic abort_test(input bit use_reset);
        line_t e;
        exp_q.delete();
        push_exp(5, 3, 7, 7);
        send_block(5, 3, 7, 7);
        @(negedge clk);
        chk("abort_first_valid", 64'(cline_valid_out), 64'd1);
        e = exp_q.pop_front();
        chk("abort_first_x", 64'(cline_x_out), 64'(e.x));
        cline_ready_in = 1'b1;
        exp_cl++;
        @(negedge clk);
        e = exp_q.pop_front();
        chk("abort_second_valid", 64'(cline_valid_out), 64'd1);
        chk("abort_second_x", 64'(cline_x_out), 64'(e.x));
        if (use_reset) reset = 1'b0;
        else flush_in = 1'b1;
        @(negedge clk);
        flush_in = 1'b0;
        reset = 1'b1;
        cline_ready_in = 1'b0;
        if (use_reset) begin
            exp_blk = 0;
            exp_cl  = 0;
            chk("rst_mid_x", 64'(cline_x_out), 64'd0);
            chk("rst_mid_y", 64'(cline_y_out), 64'd0);
            chk("rst_mid_cnt", 64'(cline_cnt_out), 64'd0);
        end
        chk("abort_valid_low", 64'(cline_valid_out), 64'd0);
        chk("abort_ready_high", 64'(blk_ready_out), 64'd1);
        chk("abort_last_low", 64'(cline_last_out), 64'd0);
        check_perf(use_reset ? "abort_rst" : "abort_flush");
        exp_q.delete();
    endtask

    vec_t vecs[6];
    int   n;

    initial begin
        vecs[0] = '{sx: 8,    sy: 4,    w: 3, h: 3, exp_cnt: 1, rnd_ready: 1'b0};
        vecs[1] = '{sx: 6,    sy: 2,    w: 4, h: 3, exp_cnt: 4, rnd_ready: 1'b0};
        vecs[2] = '{sx: 5,    sy: 3,    w: 7, h: 7, exp_cnt: 6, rnd_ready: 1'b0};
        vecs[3] = '{sx: 6,    sy: 2,    w: 4, h: 3, exp_cnt: 4, rnd_ready: 1'b1};
        vecs[4] = '{sx: 2047, sy: 0,    w: 7, h: 0, exp_cnt: 2, rnd_ready: 1'b0};
        vecs[5] = '{sx: 0,    sy: 2046, w: 0, h: 3, exp_cnt: 2, rnd_ready: 1'b1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_blk_ready", 64'(blk_ready_out), 64'd1);
        chk("rst_valid", 64'(cline_valid_out), 64'd0);
        chk("rst_last", 64'(cline_last_out), 64'd0);
        chk("rst_x", 64'(cline_x_out), 64'd0);
        chk("rst_y", 64'(cline_y_out), 64'd0);
        chk("rst_cnt", 64'(cline_cnt_out), 64'd0);
        reset = 1'b1;
        check_perf("rst");

        for (int i = 0; i < 6; i++) begin
            exp_cnt_g = vecs[i].exp_cnt;
            push_exp(vecs[i].sx, vecs[i].sy, vecs[i].w, vecs[i].h);
            send_block(vecs[i].sx, vecs[i].sy, vecs[i].w, vecs[i].h);
            run_lines(vecs[i].rnd_ready, n);
            chk("handshake_count", 64'(n), 64'(vecs[i].exp_cnt));
        end
        check_perf("table");

        // Flush while idle: must not accept the block presented alongside it.
        @(negedge clk);
        start_x_in   = 11'd8;
        start_y_in   = 11'd4;
        blk_valid_in = 1'b1;
        flush_in     = 1'b1;
        @(posedge clk);
        #1 blk_valid_in = 1'b0;
        flush_in = 1'b0;
        @(negedge clk);
        chk("idle_flush_ready", 64'(blk_ready_out), 64'd1);
        @(negedge clk);
        chk("idle_flush_no_issue", 64'(cline_valid_out), 64'd0);
        check_perf("idle_flush");

        abort_test(1'b0);
        exp_cnt_g = 4;
        push_exp(6, 2, 4, 3);
        send_block(6, 2, 4, 3);
        run_lines(1'b0, n);
        chk("after_flush_count", 64'(n), 64'd4);

        abort_test(1'b1);
        exp_cnt_g = 6;
        push_exp(5, 3, 7, 7);
        send_block(5, 3, 7, 7);
        run_lines(1'b1, n);
        chk("after_reset_count", 64'(n), 64'd6);
        check_perf("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
